// File: rtl/regfile_pkg.sv
// Shared constants and types for the parametrised register file with
// pending-write scoreboard.
package regfile_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int NREG_DEFAULT = 32;
    localparam int AW_DEFAULT   = $clog2(NREG_DEFAULT);
    localparam int REG_ZERO     = 0;

    typedef logic [XLEN_DEFAULT-1:0] xdata_t;
    typedef logic [AW_DEFAULT-1:0]   raddr_t;

endpackage

// File: rtl/sb_tracker.sv
// Pending-write scoreboard: one busy bit per register plus a registered
// up/down count of how many bits are set.
module sb_tracker
    import regfile_pkg::*;
#(
    parameter int NREG = 32,
    parameter int AW   = $clog2(NREG),
    parameter int CW   = $clog2(NREG + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_addr,
    input  logic            clr_valid,
    input  logic [AW-1:0]   clr_addr,
    input  logic            flush,
    output logic [NREG-1:0] busy,
    output logic [CW-1:0]   busy_cnt
);

    logic [NREG-1:0] busy_r;
    logic [NREG-1:0] busy_nxt_s;
    logic [CW-1:0]   cnt_r;
    logic            inc_s;
    logic            dec_s;
    logic            iss_ok_s;
    logic            clr_ok_s;

    assign iss_ok_s = iss_valid && (iss_addr != AW'(REG_ZERO));
    // A retire of the register being re-issued this cycle is dropped: the new producer owns it.
    assign clr_ok_s = clr_valid && (clr_addr != AW'(REG_ZERO)) && !(iss_ok_s && (iss_addr == clr_addr));

    // Next busy vector and the count delta derived from actual bit transitions.
    always_comb begin
        busy_nxt_s = busy_r;
        inc_s      = 1'b0;
        dec_s      = 1'b0;
        if (flush) begin
            busy_nxt_s = '0;
        end else begin
            if (clr_ok_s) begin
                dec_s                = busy_r[clr_addr];
                busy_nxt_s[clr_addr] = 1'b0;
            end else begin
                dec_s = 1'b0;
            end
            if (iss_ok_s) begin
                inc_s                = !busy_r[iss_addr];
                busy_nxt_s[iss_addr] = 1'b1;
            end else begin
                inc_s = 1'b0;
            end
        end
    end

    // Busy vector and counter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= '0;
            cnt_r  <= '0;
        end else if (flush) begin
            busy_r <= '0;
            cnt_r  <= '0;
        end else begin
            busy_r <= busy_nxt_s;
            cnt_r  <= cnt_r + CW'(inc_s) - CW'(dec_s);
        end
    end

    assign busy     = busy_r;
    assign busy_cnt = cnt_r;

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with optional write-to-read bypass and a
// per-register scoreboard for RAW hazard detection at decode.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int XLEN   = XLEN_DEFAULT,
    parameter int NREG   = NREG_DEFAULT,
    parameter int NRD    = 2,
    parameter int BYPASS = 1,
    parameter int AW     = $clog2(NREG)
) (
    input  logic                      i_clk,
    input  logic                      i_reset_n,
    input  logic [NRD*AW-1:0]         i_rs_addr,
    output logic [NRD*XLEN-1:0]       o_rs_data,
    output logic [NRD-1:0]            o_rs_busy,
    input  logic [AW-1:0]             i_rd_addr,
    input  logic [XLEN-1:0]           i_rd_data,
    input  logic                      i_rd_wren,
    input  logic                      i_iss_valid,
    input  logic [AW-1:0]             i_iss_addr,
    input  logic                      i_flush,
    output logic [$clog2(NREG+1)-1:0] o_busy_cnt
);

    localparam int CW = $clog2(NREG + 1);

    logic [XLEN-1:0] regs_r [NREG];
    logic [NREG-1:0] busy_s;
    logic            wr_ok_s;

    assign wr_ok_s = i_rd_wren && (i_rd_addr != AW'(REG_ZERO));

    // Storage array; register 0 is never written so it stays at its reset value of 0.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= '0;
            end
        end else if (wr_ok_s) begin
            regs_r[i_rd_addr] <= i_rd_data;
        end else begin
            regs_r[i_rd_addr] <= regs_r[i_rd_addr];
        end
    end

    sb_tracker #(
        .NREG (NREG),
        .AW   (AW),
        .CW   (CW)
    ) u_sb_tracker (
        .clk       (i_clk),
        .rst_n     (i_reset_n),
        .iss_valid (i_iss_valid),
        .iss_addr  (i_iss_addr),
        .clr_valid (i_rd_wren),
        .clr_addr  (i_rd_addr),
        .flush     (i_flush),
        .busy      (busy_s),
        .busy_cnt  (o_busy_cnt)
    );

    // Read ports; outputs are forced low while reset is held so a live write bus cannot leak through.
    always_comb begin
        o_rs_data = '0;
        o_rs_busy = '0;
        for (int k = 0; k < NRD; k++) begin
            logic [AW-1:0] a_s;
            logic          byp_s;
            a_s   = i_rs_addr[k*AW +: AW];
            byp_s = (BYPASS == 1) && wr_ok_s && (i_rd_addr == a_s);
            if (!i_reset_n) begin
                o_rs_data[k*XLEN +: XLEN] = '0;
                o_rs_busy[k]              = 1'b0;
            end else if (byp_s) begin
                o_rs_data[k*XLEN +: XLEN] = i_rd_data;
                o_rs_busy[k]              = 1'b0;
            end else begin
                o_rs_data[k*XLEN +: XLEN] = regs_r[a_s];
                o_rs_busy[k]              = busy_s[a_s];
            end
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench: a 4-port bypassed instance and a 2-port
// non-bypassed instance share the same write/issue/flush stimulus.
module tb_regfile_sb;

    logic        clk;
    logic        rst_n;
    logic [19:0] rs_addr;
    logic [127:0] rs_data;
    logic [3:0]  rs_busy;
    logic [9:0]  rs_addr_b;
    logic [63:0] rs_data_b;
    logic [1:0]  rs_busy_b;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        wren;
    logic        iss_valid;
    logic [4:0]  iss_addr;
    logic        flush;
    logic [5:0]  cnt;
    logic [5:0]  cnt_b;

    int errors = 0;
    int checks = 0;

    regfile_sb #(.XLEN(32), .NREG(32), .NRD(4), .BYPASS(1)) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_rs_addr(rs_addr), .o_rs_data(rs_data),
        .o_rs_busy(rs_busy), .i_rd_addr(rd_addr), .i_rd_data(rd_data), .i_rd_wren(wren),
        .i_iss_valid(iss_valid), .i_iss_addr(iss_addr), .i_flush(flush), .o_busy_cnt(cnt)
    );

    regfile_sb #(.XLEN(32), .NREG(32), .NRD(2), .BYPASS(0)) dut_nb (
        .i_clk(clk), .i_reset_n(rst_n), .i_rs_addr(rs_addr_b), .o_rs_data(rs_data_b),
        .o_rs_busy(rs_busy_b), .i_rd_addr(rd_addr), .i_rd_data(rd_data), .i_rd_wren(wren),
        .i_iss_valid(iss_valid), .i_iss_addr(iss_addr), .i_flush(flush), .o_busy_cnt(cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rs(input int k, input logic [4:0] a);
        rs_addr[k*5 +: 5] = a;
    endtask

    function automatic logic [31:0] rdat(input int k);
        return rs_data[k*32 +: 32];
    endfunction

    function automatic logic [31:0] rdat_b(input int k);
        return rs_data_b[k*32 +: 32];
    endfunction

    initial begin
        rst_n = 1'b0; rs_addr = '0; rs_addr_b = '0; rd_addr = '0; rd_data = '0;
        wren = 1'b0; iss_valid = 1'b0; iss_addr = '0; flush = 1'b0;
        #3;
        chk("reset_cnt", {26'd0, cnt}, 32'd0);
        chk("reset_data", rdat(0), 32'd0);
        tick(); rst_n = 1'b1; tick();

        // Write and issue x5, then pull reset mid-cycle
        wren = 1'b1; rd_addr = 5'd5; rd_data = 32'hDEADBEEF; iss_valid = 1'b1; iss_addr = 5'd5;
        tick();
        wren = 1'b0; iss_valid = 1'b0; set_rs(0, 5'd5); #1;
        chk("x5_written", rdat(0), 32'hDEADBEEF);
        chk("x5_cnt", {26'd0, cnt}, 32'd1);
        chk("x5_busy", {28'd0, rs_busy}, 32'h1);
        rst_n = 1'b0; #1;
        chk("async_rst_data", rdat(0), 32'd0);
        chk("async_rst_cnt", {26'd0, cnt}, 32'd0);
        chk("async_rst_busy", {28'd0, rs_busy}, 32'd0);
        tick(); rst_n = 1'b1; tick();
        chk("x5_after_rst", rdat(0), 32'd0);

        // Register 0: write and issue ignored, bypass suppressed
        wren = 1'b1; rd_addr = 5'd0; rd_data = 32'h1234; iss_valid = 1'b1; iss_addr = 5'd0;
        set_rs(0, 5'd0); #1;
        chk("x0_no_bypass", rdat(0), 32'd0);
        tick(); wren = 1'b0; iss_valid = 1'b0; #1;
        chk("x0_read", rdat(0), 32'd0);
        chk("x0_busy", {28'd0, rs_busy}, 32'd0);
        chk("x0_cnt", {26'd0, cnt}, 32'd0);

        // Write x7: bypass same cycle on dut, stored value next cycle on both
        wren = 1'b1; rd_addr = 5'd7; rd_data = 32'hA5A5A5A5;
        set_rs(0, 5'd7); set_rs(1, 5'd7); rs_addr_b = {5'd7, 5'd7}; #1;
        chk("x7_bypass", rdat(0), 32'hA5A5A5A5);
        chk("x7_nobypass_old", rdat_b(0), 32'd0);
        tick(); wren = 1'b0; #1;
        chk("x7_p0", rdat(0), 32'hA5A5A5A5);
        chk("x7_p1", rdat(1), 32'hA5A5A5A5);
        chk("x7_nb_p1", rdat_b(1), 32'hA5A5A5A5);

        // Bypass off: same-cycle read sees old value
        wren = 1'b1; rd_addr = 5'd3; rd_data = 32'h11; tick();
        rd_data = 32'h22; rs_addr_b[4:0] = 5'd3; set_rs(0, 5'd3); #1;
        chk("x3_nb_old", rdat_b(0), 32'h11);
        chk("x3_byp_new", rdat(0), 32'h22);
        tick(); wren = 1'b0; #1;
        chk("x3_nb_new", rdat_b(0), 32'h22);

        // Scoreboard set/clear on x9
        iss_valid = 1'b1; iss_addr = 5'd9; tick(); iss_valid = 1'b0;
        set_rs(0, 5'd9); rs_addr_b[4:0] = 5'd9; #1;
        chk("x9_busy", {31'd0, rs_busy[0]}, 32'd1);
        chk("x9_cnt", {26'd0, cnt}, 32'd1);
        wren = 1'b1; rd_addr = 5'd9; rd_data = 32'h99; #1;
        chk("x9_fwd_busy0", {31'd0, rs_busy[0]}, 32'd0);
        chk("x9_nb_busy1", {31'd0, rs_busy_b[0]}, 32'd1);
        tick(); wren = 1'b0; #1;
        chk("x9_retired", {31'd0, rs_busy[0]}, 32'd0);
        chk("x9_cnt0", {26'd0, cnt}, 32'd0);
        iss_valid = 1'b1; tick();
        wren = 1'b1; tick(); iss_valid = 1'b0; wren = 1'b0; #1;
        chk("x9_issue_wins", {31'd0, rs_busy[0]}, 32'd1);
        chk("x9_issue_wins_cnt", {26'd0, cnt}, 32'd1);
        iss_valid = 1'b1; tick(); iss_valid = 1'b0; #1;
        chk("x9_reissue_cnt", {26'd0, cnt}, 32'd1);
        wren = 1'b1; tick(); wren = 1'b0; #1;
        chk("x9_clear_cnt", {26'd0, cnt}, 32'd0);

        // Count concurrency
        iss_valid = 1'b1; iss_addr = 5'd4; tick();
        iss_addr = 5'd5; tick();
        iss_addr = 5'd6; tick(); iss_valid = 1'b0; #1;
        chk("cnt3", {26'd0, cnt}, 32'd3);
        iss_valid = 1'b1; iss_addr = 5'd8; wren = 1'b1; rd_addr = 5'd4; rd_data = 32'h44;
        tick(); iss_valid = 1'b0; wren = 1'b0;
        set_rs(0, 5'd4); set_rs(1, 5'd8); #1;
        chk("cnt3_swap", {26'd0, cnt}, 32'd3);
        chk("swap_busy", {28'd0, rs_busy}, 32'h2);
        chk("nb_cnt3", {26'd0, cnt_b}, 32'd3);
        flush = 1'b1; iss_valid = 1'b1; iss_addr = 5'd10; tick();
        flush = 1'b0; iss_valid = 1'b0; set_rs(2, 5'd10); #1;
        chk("flush_cnt", {26'd0, cnt}, 32'd0);
        chk("flush_busy", {28'd0, rs_busy}, 32'd0);

        // Multi-port reads with x31 pending
        wren = 1'b1; rd_addr = 5'd1; rd_data = 32'd1; tick();
        rd_addr = 5'd2; rd_data = 32'd2; tick();
        rd_addr = 5'd31; rd_data = 32'hFFFFFFFF; tick(); wren = 1'b0;
        iss_valid = 1'b1; iss_addr = 5'd31; tick(); iss_valid = 1'b0;
        set_rs(0, 5'd1); set_rs(1, 5'd2); set_rs(2, 5'd1); set_rs(3, 5'd31); #1;
        chk("mp_p0", rdat(0), 32'd1);
        chk("mp_p1", rdat(1), 32'd2);
        chk("mp_p2", rdat(2), 32'd1);
        chk("mp_p3", rdat(3), 32'hFFFFFFFF);
        chk("mp_busy", {28'd0, rs_busy}, 32'h8);
        chk("mp_cnt", {26'd0, cnt}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the RV32I register file, for the pipelined core.
- Features:
  - configurable XLEN, register count and number of read ports
  - optional write-to-read bypass
  - per-register pending-write scoreboard, so decode can detect RAW hazards against in-flight writes
- Sits between decode (reads, issue) and writeback (writes, retire).

Parameters:
- XLEN, 32, data width of each register.
- NREG, 32, number of architectural registers; power of two, at least 2.
- NRD, 2, number of independent read ports, 1 to 4.
- BYPASS, 1, 1 = a read of the register being written this cycle returns i_rd_data; 0 = returns the stored value.
- AW, $clog2(NREG), address width (derived; do not override).

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_reset_n  in  1  asynchronous active-low reset.
- i_rs_addr  in  NRD*AW  read addresses; port k uses bits [k*AW +: AW].
- o_rs_data  out  NRD*XLEN  read data; port k uses bits [k*XLEN +: XLEN]; combinational.
- o_rs_busy  out  NRD  port k source has a pending write; combinational.
- i_rd_addr  in  AW  writeback address.
- i_rd_data  in  XLEN  writeback data.
- i_rd_wren  in  1  writeback enable; also retires the scoreboard entry for i_rd_addr.
- i_iss_valid  in  1  an instruction with destination i_iss_addr issues this cycle.
- i_iss_addr  in  AW  destination of the issuing instruction.
- i_flush  in  1  synchronous clear of all scoreboard bits; register contents are unaffected.
- o_busy_cnt  out  $clog2(NREG+1)  registered count of set busy bits.

Behaviour:
- Reset (i_reset_n low, asynchronous):
  - all registers, busy bits and o_busy_cnt go to 0 immediately.
  - o_rs_data = 0 and o_rs_busy = 0 for every address while reset is held.
- Register 0:
  - hardwired to 0; writes to it are ignored.
  - its busy bit is never set; issue to address 0 is ignored.
  - reads of it return 0 and busy 0, including under bypass.
- Write:
  - on a rising edge with i_rd_wren=1 and i_rd_addr≠0, reg[i_rd_addr] <= i_rd_data.
  - visible to a non-bypassed read the following cycle.
- Read:
  - purely combinational, 0-cycle latency; ports are independent and may alias.
  - with BYPASS=1, i_rd_wren=1 and i_rs_addr[k]==i_rd_addr≠0: o_rs_data[k] = i_rd_data in the same cycle.
- Scoreboard, per register r≠0, next-state priority order:
  1. i_flush=1 → busy[r] <= 0 (overrides everything).
  2. i_iss_valid && i_iss_addr==r → busy[r] <= 1. When this coincides with a retire of the same r, issue wins (the new producer owns r).
  3. i_rd_wren && i_rd_addr==r → busy[r] <= 0.
  4. otherwise hold.
- Writes complete regardless of the busy bit; there is no check that a write matches an issue.
- o_rs_busy[k]:
  - = busy[i_rs_addr[k]], except forced to 0 when BYPASS=1 and the same-cycle write targets that address (the value is forwarded).
  - with BYPASS=0 it shows the registered busy bit unmodified.
- o_busy_cnt:
  - registered; equals the popcount of the busy vector after each edge.
  - maintained as an up/down counter: +1 on a 0→1 transition, −1 on a 1→0 transition, net 0 when both occur on different registers in the same cycle.
  - set to 0 on flush.
  - never exceeds NREG−1.
- Re-issue of an already busy register: the bit stays 1 and the count does not change.
- Reset mid-operation discards all pending state; there is no recovery of in-flight entries.

Decomposition:
- Shared package regfile_pkg:
  - default XLEN/NREG constants
  - localparam REG_ZERO = 0
  - typedef logic [XLEN-1:0] xdata_t
  - typedef logic [AW-1:0] raddr_t
- One sub-module, sb_tracker:
  - holds the busy vector, set/clear/flush priority and the o_busy_cnt up/down counter.
  - the storage array and read-port/bypass muxing stay in regfile_sb.

Test Plan:
- Reset and zero register: assert i_reset_n=0 mid-run after writing x5=0xDEADBEEF → x5 reads 0 and o_busy_cnt=0 asynchronously. Then write x0=0x1234 → x0 reads 0 and busy stays 0.
- Write then read: write x7=0xA5A5A5A5 at edge 1 → port0 addr 7 and port1 addr 7 both return 0xA5A5A5A5 from cycle 2. With BYPASS=1, addr 7 also returns the new value in cycle 1.
- Bypass off: BYPASS=0, x3=0x11, write x3=0x22 and read x3 in the same cycle → 0x11; next cycle 0x22.
- Scoreboard set/clear: issue x9 → next cycle o_rs_busy=1 for addr 9 and o_busy_cnt=1. Write x9 → busy 0, count 0. Issue x9 and write x9 in the same cycle while busy → busy stays 1, count stays 1.
- Count concurrency: issue x4, x5, x6 on successive cycles → count 3. Issue x8 while writing x4 → count stays 3. Flush while also issuing x10 → all busy 0, count 0.
- Multi-port: NRD=4, four ports read x1, x2, x1, x31 loaded with 1, 2, 1, 0xFFFFFFFF → each port returns its own value. With x31 pending, only port 3 shows busy.
